// File: rtl/shift_sequencer.sv
// Multi-cycle right shifter: one bit position per clock, arithmetic or logical,
// with valid/ready handshakes on both the request and result sides.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] wreg;
  logic [CW-1:0]    count;
  logic [CW-1:0]    eff;
  logic             mode;
  logic             accept;

  assign in_ready  = (state == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign out_data  = wreg;
  assign busy      = (state != IDLE);

  // Amounts of WIDTH or more saturate to exactly WIDTH shifts.
  always_comb begin
    eff = '0;
    if (int'(in_amt) >= WIDTH) eff = CW'(WIDTH);
    else                       eff = CW'(in_amt);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (eff == '0) ? DONE : SHIFT;
      SHIFT:   if (count == CW'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wreg  <= '0;
      count <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            wreg  <= in_data;
            mode  <= in_mode;
            count <= eff;
          end
        end
        SHIFT: begin
          wreg  <= {(mode ? 1'b0 : wreg[WIDTH-1]), wreg[WIDTH-1:1]};
          count <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed and random requests compared
// against an arithmetic reference model of the shift result and latency.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  in_amt;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int errors = 0;
  int checks = 0;

  shift_sequencer #(.WIDTH(16), .AMT_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_of(input logic [4:0] a);
    return (int'(a) >= 16) ? 16 : int'(a);
  endfunction

  function automatic logic [15:0] model(input logic [15:0] d, input logic [4:0] a, input logic m);
    logic signed [15:0] s;
    int e;
    e = eff_of(a);
    s = $signed(d);
    if (m) return d >> e;
    return 16'(s >>> e);
  endfunction

  // One complete transaction: accept, wait for result, optional backpressure, handshake out.
  task automatic run_op(input string tag, input logic [15:0] d, input logic [4:0] a,
                        input logic m, input int bp, input bit scramble);
    logic [15:0] exp;
    int e;
    int cyc;
    exp = model(d, a, m);
    e   = eff_of(a);
    check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = a;
    in_mode   = m;
    out_ready = (bp == 0);
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      if (scramble) begin
        in_data  = 16'($urandom);
        in_amt   = 5'($urandom);
        in_mode  = 1'($urandom);
        in_valid = 1'($urandom);
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, 32'(cyc), 32'(e));
    check({tag, ".data"}, 32'(out_data), 32'(exp));
    check({tag, ".busy"}, 32'(busy), 32'd1);
    check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < bp; i++) begin
      in_valid = (i == 1);
      in_data  = 16'($urandom);
      step();
      check({tag, ".bp_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".bp_data"}, 32'(out_data), 32'(exp));
      check({tag, ".bp_busy"}, 32'(busy), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data", 32'(out_data), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.in_ready_in_reset", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rst.in_ready_released", 32'(in_ready), 32'd1);

    run_op("arith1", 16'h8001, 5'd1, 1'b0, 0, 1'b0);
    run_op("logic4", 16'h8001, 5'd4, 1'b1, 0, 1'b0);
    run_op("arith4", 16'h8001, 5'd4, 1'b0, 0, 1'b0);
    run_op("zero", 16'h1234, 5'd0, 1'b0, 0, 1'b0);
    run_op("sat_arith", 16'h8000, 5'd20, 1'b0, 0, 1'b0);
    run_op("sat_logic", 16'h8000, 5'd20, 1'b1, 0, 1'b0);
    run_op("exact16", 16'hA5A5, 5'd16, 1'b0, 0, 1'b0);
    run_op("amt15", 16'hC000, 5'd15, 1'b1, 0, 1'b0);
    run_op("backpressure", 16'h9ABC, 5'd3, 1'b0, 5, 1'b0);
    run_op("scramble", 16'hF0F0, 5'd7, 1'b1, 0, 1'b1);
    run_op("scramble_bp", 16'h8421, 5'd9, 1'b0, 2, 1'b1);

    // Reset in the middle of a 10-bit shift.
    in_valid  = 1'b1;
    in_data   = 16'hBEEF;
    in_amt    = 5'd10;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("midrst.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.out_data", 32'(out_data), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    run_op("after_rst", 16'h7001, 5'd2, 1'b0, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      run_op("random", 16'($urandom), 5'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
